// File: rtl/alu_memory.sv
// alu_memory: execution + data-memory slice of a single-cycle LEGv8-style datapath.
//
// A 32-bit combinational ALU feeds a word-storage data memory whose write data
// is the ALU result.
//
// Ports:
//   clk          rising-edge clock for memory writes and reset
//   rst          synchronous, active-high reset; clears every memory slot
//   ALUOp        4-bit operation select
//   A, B         operands (B[4:0] is the shift amount for shift ops)
//   imm          immediate operand, used by ADDI only
//   Result       combinational ALU result, also the memory write data
//   Zero         high when Result == 0
//   address      byte address; slot index = address >> 3, address[2:0] ignored
//   write_enable store strobe, sampled at rising clk
//   read_data    asynchronous read of the addressed slot, 0 when out of range
module alu_memory #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] imm,
  output logic [31:0] Result,
  output logic        Zero,
  input  logic [31:0] address,
  input  logic        write_enable,
  output logic [31:0] read_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_ADDI = 4'b0001,
    OP_LSL  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_ORR  = 4'b0101,
    OP_EOR  = 4'b0110,
    OP_LSR  = 4'b0111,
    OP_ASR  = 4'b1000,
    OP_MOVB = 4'b1001
  } alu_op_t;

  alu_op_t op;
  assign op = alu_op_t'(ALUOp);

  always_comb begin
    Result = '0;
    case (op)
      OP_ADD:  Result = A + B;
      OP_ADDI: Result = A + imm;
      OP_LSL:  Result = A << B[4:0];
      OP_SUB:  Result = A - B;
      OP_AND:  Result = A & B;
      OP_ORR:  Result = A | B;
      OP_EOR:  Result = A ^ B;
      OP_LSR:  Result = A >> B[4:0];
      OP_ASR:  Result = $signed(A) >>> B[4:0];
      OP_MOVB: Result = B;
      default: Result = '0;
    endcase
  end

  assign Zero = ~|Result;

  // Slots are 8 bytes apart; the low three address bits select nothing.
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] slot;
  logic          in_range;
  logic          unused_addr_bits;

  assign slot             = address[AW+2:3];
  assign in_range         = (address[31:3] >> AW) == '0;
  assign unused_addr_bits = &address[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enable && in_range) begin
      mem[slot] <= Result;
    end
  end

  assign read_data = in_range ? mem[slot] : '0;

endmodule

// File: tb/tb_alu_memory.sv
module tb_alu_memory;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ALUOp;
  logic [31:0] A, B, imm;
  logic [31:0] Result;
  logic        Zero;
  logic [31:0] address;
  logic        write_enable;
  logic [31:0] read_data;

  int n_cmp = 0;
  int n_bad = 0;

  alu_memory #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .A(A), .B(B), .imm(imm),
    .Result(Result), .Zero(Zero), .address(address),
    .write_enable(write_enable), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [31:0] mdl [DEPTH];
  bit          mdl_valid = 0;

  function automatic logic [31:0] alu_model(logic [3:0] op, logic [31:0] a,
                                            logic [31:0] b, logic [31:0] im);
    int unsigned sh;
    logic [63:0] ext;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a + im;
      4'd2: return a * (32'd1 << sh);
      4'd3: return a + (~b + 32'd1);
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return a / (32'd1 << sh);
      4'd8: begin
        ext = {{32{a[31]}}, a};
        ext = ext >> sh;
        return ext[31:0];
      end
      4'd9: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mem_model(logic [31:0] addr);
    longint unsigned idx;
    idx = longint'(addr) / 8;
    if (idx >= DEPTH) return 32'd0;
    return mdl[idx];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model memory update at each rising edge, from the inputs present at that edge
  always @(posedge clk) begin
    longint unsigned idx;
    idx = longint'(address) / 8;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
      mdl_valid = 1;
    end else if (write_enable && idx < DEPTH) begin
      mdl[idx] = alu_model(ALUOp, A, B, imm);
    end
  end

  // Single compare process: every falling edge
  always @(negedge clk) begin
    logic [31:0] er;
    er = alu_model(ALUOp, A, B, imm);
    chk("model_result", Result, er);
    chk("model_zero", {31'd0, Zero}, {31'd0, er == 32'd0});
    if (mdl_valid) chk("model_read", read_data, mem_model(address));
  end

  task automatic set_in(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] im, logic [31:0] addr, logic we, logic r);
    ALUOp = op; A = a; B = b; imm = im;
    address = addr; write_enable = we; rst = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_lit(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] im, logic [31:0] exp_r, logic exp_z);
    set_in(op, a, b, im, 32'd0, 1'b0, 1'b0);
    #1;
    chk(name, Result, exp_r);
    chk({name, "_zero"}, {31'd0, Zero}, {31'd0, exp_z});
  endtask

  task automatic read_lit(string name, logic [31:0] addr, logic [31:0] exp);
    address = addr; write_enable = 1'b0;
    #1;
    chk(name, read_data, exp);
  endtask

  task automatic store(logic [31:0] addr, logic [31:0] val);
    set_in(4'd9, 32'd0, val, 32'd0, addr, 1'b1, 1'b0);
    step();
    write_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] va, vb;
    set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    rst = 1'b0;

    alu_lit("add_0_0",   4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    alu_lit("addi_20",   4'd1, 32'd0, 32'hDEAD, 32'd20, 32'd20, 1'b0);
    alu_lit("lsl_2_3",   4'd2, 32'd2, 32'd3, 32'd0, 32'd16, 1'b0);
    alu_lit("sub_5_7",   4'd3, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 1'b0);
    alu_lit("sub_20_20", 4'd3, 32'd20, 32'd20, 32'd0, 32'd0, 1'b1);
    alu_lit("asr_neg",   4'd8, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 1'b0);
    alu_lit("lsr_neg",   4'd7, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 1'b0);
    alu_lit("op_1100",   4'hC, 32'h1234, 32'h5678, 32'd1, 32'd0, 1'b1);
    alu_lit("lsl_mask",  4'd2, 32'd1, 32'd33, 32'd0, 32'd2, 1'b0);
    alu_lit("movb",      4'd9, 32'd7, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 1'b0);
    step();

    // Store/load
    set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    set_in(4'd1, 32'd0, 32'd0, 32'd42, 32'd16, 1'b1, 1'b0);
    step();
    read_lit("ld_16", 32'd16, 32'd42);
    read_lit("ld_23", 32'd23, 32'd42);
    read_lit("ld_24", 32'd24, 32'd0);
    step();

    // Difference-array kernel
    store(32'd0, 32'd10);
    store(32'd8, 32'd7);
    store(32'd16, 32'd3);
    store(32'd24, 32'd1);
    for (int k = 0; k < 3; k++) begin
      address = 32'(8 * k);     #1; va = read_data;
      address = 32'(8 * k + 8); #1; vb = read_data;
      set_in(4'd3, va, vb, 32'd0, 32'h400 + 32'(8 * k), 1'b1, 1'b0);
      step();
      write_enable = 1'b0;
    end
    read_lit("diff_0", 32'h400, 32'd3);
    read_lit("diff_1", 32'h408, 32'd4);
    read_lit("diff_2", 32'h410, 32'd2);
    step();

    // Reset clears and suppresses a concurrent write
    for (int k = 0; k < 4; k++) store(32'(8 * k), 32'(11 + k));
    read_lit("pre_rst_2", 32'd16, 32'd13);
    set_in(4'd9, 32'd0, 32'h99, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) read_lit("rst_clear", 32'(8 * k), 32'd0);
    step();

    // Out of range and last slot
    store(32'd0, 32'h77);
    store(32'(8 * DEPTH), 32'h55);
    read_lit("oor_read", 32'(8 * DEPTH), 32'd0);
    read_lit("oor_slot0", 32'd0, 32'h77);
    store(32'(8 * (DEPTH - 1)), 32'hABCD);
    read_lit("last_slot", 32'(8 * (DEPTH - 1)) + 32'd7, 32'hABCD);
    step();

    // Randomized phase, checked by the compare process
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ra, rb, ri, rad;
      ra = $urandom; rb = $urandom; ri = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb % 40;
      if ($urandom_range(0, 7) == 0) rb = ra;
      case ($urandom_range(0, 9))
        0:       rad = $urandom;
        1:       rad = 32'(8 * DEPTH) + $urandom_range(0, 63);
        default: rad = $urandom_range(0, 8 * 16 - 1);
      endcase
      set_in(4'($urandom_range(0, 15)), ra, rb, ri, rad,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      step();
    end

    set_in(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
